mycpu_div: RTL

- Multi-cycle radix-2 restoring divider serving the EX stage for DIV/DIVU.
- EX raises start_i with operands and holds its stall request until ready_o.
- Result goes back to EX as {remainder, quotient} and is written to HI/LO through the existing hilo path.
- Signed and unsigned 32-bit division, one quotient bit per cycle; EX can annul an in-flight divide.

---
 rtl/mycpu_div_if.sv | 37 +++
 rtl/mycpu_div.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mycpu_div_if.sv
// mycpu_div_if: request/response bundle between the EX stage and the divider.
//
// Handshake: EX raises start_i together with signed_div_i/opdata1_i/opdata2_i
// and keeps start_i high until it sees ready_o. The divider samples the
// operands only on the cycle it accepts start_i in IDLE. ready_o marks result_o
// valid, and both hold until EX drops start_i or raises annul_i. annul_i
// abandons the current operation, and that operation then produces no result.
//
// Signals:
//   start_i       EX -> div  request divide
//   signed_div_i  EX -> div  1 = DIV (signed), 0 = DIVU
//   opdata1_i     EX -> div  dividend
//   opdata2_i     EX -> div  divisor
//   annul_i       EX -> div  abort current divide
//   result_o      div -> EX  {remainder, quotient}
//   ready_o       div -> EX  result_o valid
//   state         div -> obs FSM state (0 IDLE, 1 DIV_ZERO, 2 DIV_ON, 3 DIV_END)
interface mycpu_div_if;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic [1:0]  state;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, state
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, state
  );
endinterface

// File: rtl/mycpu_div.sv
// mycpu_div: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// The divider produces one quotient bit per cycle on magnitudes, then fixes
// the signs on the way into DIV_END. A zero divisor skips the iteration and
// returns 0.
//
// Ports:
//   clk  core clock
//   rst  asynchronous active-high reset
//   bus  mycpu_div_if.slave (start/operands/annul in, result/ready/state out)
module mycpu_div #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mycpu_div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } state_t;

  state_t             state;
  logic [4:0]         counter;
  logic [WIDTH-1:0]   dividend;   // shifts left, MSB feeds the trial each cycle
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               neg_dividend;
  logic               neg_divisor;
  logic               is_signed;
  logic [2*WIDTH-1:0] result;
  logic               ready;

  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;

  // Magnitudes in signed mode. Negating 0x80000000 gives 0x80000000, which is
  // already the correct unsigned magnitude.
  assign abs1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? (~bus.opdata1_i + 1'b1)
                                                             : bus.opdata1_i;
  assign abs2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? (~bus.opdata2_i + 1'b1)
                                                             : bus.opdata2_i;

  // Partial remainder stays below the divisor, so bit WIDTH of the trial is the
  // borrow, which tells whether the shifted remainder fits.
  always_comb begin
    trial    = {rem, dividend[WIDTH-1]} - {1'b0, divisor};
    rem_next = {rem[WIDTH-2:0], dividend[WIDTH-1]};
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      dividend     <= '0;
      divisor      <= '0;
      rem          <= '0;
      quo          <= '0;
      neg_dividend <= 1'b0;
      neg_divisor  <= 1'b0;
      is_signed    <= 1'b0;
      result       <= '0;
      ready        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready  <= 1'b0;
          result <= '0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= DIV_ZERO;
            end else begin
              state        <= DIV_ON;
              counter      <= '0;
              dividend     <= abs1;
              divisor      <= abs2;
              rem          <= '0;
              quo          <= '0;
              is_signed    <= bus.signed_div_i;
              neg_dividend <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
              neg_divisor  <= bus.signed_div_i & bus.opdata2_i[WIDTH-1];
            end
          end
        end
        DIV_ZERO: begin
          state  <= DIV_END;
          result <= '0;
          ready  <= 1'b1;
        end
        DIV_ON: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            rem      <= rem_next;
            quo      <= quo_next;
            dividend <= {dividend[WIDTH-2:0], 1'b0};
            counter  <= counter + 5'd1;
            if (counter == 5'd31) begin
              state <= DIV_END;
              ready <= 1'b1;
              result[WIDTH-1:0] <= (is_signed && (neg_dividend != neg_divisor))
                                   ? (~quo_next + 1'b1) : quo_next;
              result[2*WIDTH-1:WIDTH] <= (is_signed && neg_dividend)
                                         ? (~rem_next + 1'b1) : rem_next;
            end
          end
        end
        DIV_END: begin
          // Holding start keeps the result while EX is stalled for another reason.
          if (bus.annul_i || !bus.start_i) begin
            state  <= IDLE;
            ready  <= 1'b0;
            result <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.state    = state;

endmodule
